// File: rtl/bam_receiver.sv
// BAM (binary angle modulation) line receiver: majority-decodes a frame of
// VALUE_W slots (slot k lasts 2^k ticks, LSB first) into o_VALUE.
// Ports:
//   i_clk, i_arst_n            clock, async active-low reset
//   i_DATA, i_CFG_WE           config write: PRESC=[15:0], EN=[16]
//   i_SYNC                     frame-start strobe
//   i_BAM_IN                   asynchronous BAM pin
//   i_ERR_CLR                  clears sticky o_ERR
//   i_DIN_RE                   status read enable -> o_DIN
//   o_VALUE, o_VALID           decoded value, one-cycle update pulse
//   o_ERR                      sticky frame-alignment error
//   o_DIN                      registered status {0, o_ERR, o_VALUE}
module bam_receiver #(
  parameter int VALUE_W = 8
) (
  input  logic               i_clk,
  input  logic               i_arst_n,
  input  logic [31:0]        i_DATA,
  input  logic               i_CFG_WE,
  input  logic               i_SYNC,
  input  logic               i_BAM_IN,
  input  logic               i_ERR_CLR,
  input  logic               i_DIN_RE,
  output logic [VALUE_W-1:0] o_VALUE,
  output logic               o_VALID,
  output logic               o_ERR,
  output logic [31:0]        o_DIN
);

  localparam int KW = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
  localparam int CW = VALUE_W + 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SYNC,
    RUN
  } state_t;

  state_t state;

  logic [15:0]        presc_q;
  logic [15:0]        presc_act;
  logic               en_q;
  logic [1:0]         sync_ff;
  logic               bam_s;
  logic [15:0]        pcnt;
  logic [KW-1:0]      slot;
  logic [CW-1:0]      tcnt;
  logic [CW-1:0]      hcnt;
  logic [VALUE_W-1:0] bits;

  logic               tick;
  logic [CW-1:0]      slot_len;
  logic [CW-1:0]      hc_n;
  logic               slot_end;
  logic               bit_n;
  logic [VALUE_W-1:0] bits_n;
  logic               last_slot;
  logic               sync_err;
  logic [31:0]        din_word;

  logic unused_data;
  assign unused_data = ^i_DATA[31:17];

  assign bam_s = sync_ff[1];

  always_comb begin
    tick      = (pcnt == presc_act);
    slot_len  = CW'(1) << slot;
    hc_n      = hcnt + CW'(bam_s);
    slot_end  = (tcnt == slot_len - CW'(1));
    // strict majority: 2*high > slot length
    bit_n     = {hc_n[CW-2:0], 1'b0} > slot_len;
    bits_n    = bits;
    bits_n[slot] = bit_n;
    last_slot = (slot == KW'(VALUE_W - 1));
    // o_VALID high marks the cycle right after a frame completed,
    // where a SYNC is a legal realignment
    sync_err  = (state == RUN) && i_SYNC && !o_VALID;
    din_word  = '0;
    din_word[VALUE_W:0] = {o_ERR, o_VALUE};
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      presc_q <= '0;
      en_q    <= 1'b0;
    end else if (i_CFG_WE) begin
      presc_q <= i_DATA[15:0];
      en_q    <= i_DATA[16];
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[0], i_BAM_IN};
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_DIN <= '0;
    end else if (i_DIN_RE) begin
      o_DIN <= din_word;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state     <= IDLE;
      presc_act <= '0;
      pcnt      <= '0;
      slot      <= '0;
      tcnt      <= '0;
      hcnt      <= '0;
      bits      <= '0;
      o_VALUE   <= '0;
      o_VALID   <= 1'b0;
      o_ERR     <= 1'b0;
    end else begin
      o_VALID <= 1'b0;
      if (sync_err) begin
        o_ERR <= 1'b1;
      end else if (i_ERR_CLR) begin
        o_ERR <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          presc_act <= presc_q;
          pcnt      <= '0;
          slot      <= '0;
          tcnt      <= '0;
          hcnt      <= '0;
          bits      <= '0;
          if (en_q) begin
            state <= WAIT_SYNC;
          end
        end
        WAIT_SYNC: begin
          presc_act <= presc_q;
          pcnt      <= '0;
          slot      <= '0;
          tcnt      <= '0;
          hcnt      <= '0;
          bits      <= '0;
          if (!en_q) begin
            state <= IDLE;
          end else if (i_SYNC) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (!en_q) begin
            state <= IDLE;
            pcnt  <= '0;
            slot  <= '0;
            tcnt  <= '0;
            hcnt  <= '0;
            bits  <= '0;
          end else if (i_SYNC) begin
            // realign (or error restart): new frame from slot 0
            presc_act <= presc_q;
            pcnt      <= '0;
            slot      <= '0;
            tcnt      <= '0;
            hcnt      <= '0;
            bits      <= '0;
          end else if (tick) begin
            // new PRESC only takes effect at the wrap
            pcnt      <= '0;
            presc_act <= presc_q;
            if (slot_end) begin
              tcnt <= '0;
              hcnt <= '0;
              if (last_slot) begin
                slot    <= '0;
                bits    <= '0;
                o_VALUE <= bits_n;
                o_VALID <= 1'b1;
              end else begin
                slot <= slot + KW'(1);
                bits <= bits_n;
              end
            end else begin
              tcnt <= tcnt + CW'(1);
              hcnt <= hc_n;
            end
          end else begin
            pcnt <= pcnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bam_receiver.sv
// Directed bench for bam_receiver: table of single-frame decodes plus
// sequences for back-to-back frames, realign, abort, error and reset.
module tb_bam_receiver;

  logic        i_clk = 1'b0;
  logic        i_arst_n = 1'b0;
  logic [31:0] i_DATA = '0;
  logic        i_CFG_WE = 1'b0;
  logic        i_SYNC = 1'b0;
  logic        i_BAM_IN = 1'b0;
  logic        i_ERR_CLR = 1'b0;
  logic        i_DIN_RE = 1'b0;
  logic [7:0]  o_VALUE;
  logic        o_VALID;
  logic        o_ERR;
  logic [31:0] o_DIN;

  bam_receiver #(.VALUE_W(8)) dut (
    .i_clk     (i_clk),
    .i_arst_n  (i_arst_n),
    .i_DATA    (i_DATA),
    .i_CFG_WE  (i_CFG_WE),
    .i_SYNC    (i_SYNC),
    .i_BAM_IN  (i_BAM_IN),
    .i_ERR_CLR (i_ERR_CLR),
    .i_DIN_RE  (i_DIN_RE),
    .o_VALUE   (o_VALUE),
    .o_VALID   (o_VALID),
    .o_ERR     (o_ERR),
    .o_DIN     (o_DIN)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] fv [4];
  int cur_p = 0;
  int g_slot = -1;
  int g_n = 0;
  int rel = -1000;
  int nv = 0;
  int vrel [8];
  logic [7:0] vval [8];

  typedef struct {
    int         p;
    logic [7:0] v;
    int         gs;
    int         gn;
    logic [7:0] e;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Pin level for cycle r (r=0 is the SYNC cycle); the 2-flop
  // synchronizer means tick t samples the pin two cycles earlier.
  function automatic logic pin_for(input int r);
    int m, t, fr, f, k, o;
    m = r + 1;
    if (m < 0) return 1'b0;
    t = m / (cur_p + 1);
    fr = t / 255;
    f = t % 255;
    if (fr > 3) fr = 3;
    k = 0;
    while (((1 << (k + 1)) - 1) <= f) k++;
    o = f - ((1 << k) - 1);
    if (k == g_slot && o < g_n) return 1'b0;
    return fv[fr][k];
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
    rel++;
    i_BAM_IN = pin_for(rel);
    if (o_VALID) begin
      if (nv < 8) begin
        vrel[nv] = rel;
        vval[nv] = o_VALUE;
      end
      nv++;
    end
  endtask

  task automatic cfg(input bit en, input int p);
    i_DATA = {15'd0, en, 16'(p)};
    i_CFG_WE = 1'b1;
    step();
    i_CFG_WE = 1'b0;
  endtask

  task automatic start_frame(input bit clr);
    rel = -2;
    step();
    step();
    i_SYNC = 1'b1;
    i_ERR_CLR = clr;
    step();
    i_SYNC = 1'b0;
    i_ERR_CLR = 1'b0;
  endtask

  task automatic run_to(input int r);
    while (rel < r) step();
  endtask

  initial begin
    int tgt;
    tbl[0] = '{0, 8'hA5, -1, 0,  8'hA5};
    tbl[1] = '{1, 8'h5A, -1, 0,  8'h5A};
    tbl[2] = '{0, 8'h80, 7,  60, 8'h80};
    tbl[3] = '{0, 8'h80, 7,  64, 8'h00};
    tbl[4] = '{2, 8'h3C, -1, 0,  8'h3C};
    tbl[5] = '{0, 8'h00, -1, 0,  8'h00};
    tbl[6] = '{0, 8'hFF, -1, 0,  8'hFF};
    tbl[7] = '{0, 8'h06, 2,  2,  8'h02};
    tbl[8] = '{0, 8'h06, 2,  1,  8'h06};
    for (int i = 0; i < 4; i++) fv[i] = 8'h00;

    repeat (3) step();
    chk("rst_value", 32'(o_VALUE), 32'h0);
    chk("rst_valid", 32'(o_VALID), 32'h0);
    chk("rst_err", 32'(o_ERR), 32'h0);
    chk("rst_din", o_DIN, 32'h0);
    i_arst_n = 1'b1;
    repeat (3) step();

    for (int i = 0; i < 9; i++) begin
      cur_p = tbl[i].p;
      g_slot = tbl[i].gs;
      g_n = tbl[i].gn;
      for (int j = 0; j < 4; j++) fv[j] = tbl[i].v;
      cfg(1'b1, cur_p);
      step();
      nv = 0;
      start_frame(1'b0);
      tgt = 255 * (cur_p + 1) + 1;
      run_to(tgt);
      chk($sformatf("tbl%0d_nvalid", i), 32'(nv), 32'd1);
      chk($sformatf("tbl%0d_value", i), 32'(vval[0]), 32'(tbl[i].e));
      chk($sformatf("tbl%0d_when", i), 32'(vrel[0]), 32'(tgt));
      cfg(1'b0, 0);
      repeat (3) step();
    end
    g_slot = -1;
    g_n = 0;

    // back-to-back frames without SYNC
    cur_p = 3;
    fv[0] = 8'h01;
    fv[1] = 8'hFF;
    cfg(1'b1, 3);
    step();
    nv = 0;
    start_frame(1'b0);
    run_to(2041);
    chk("b2b_nvalid", 32'(nv), 32'd2);
    chk("b2b_val0", 32'(vval[0]), 32'h01);
    chk("b2b_val1", 32'(vval[1]), 32'hFF);
    chk("b2b_t0", 32'(vrel[0]), 32'd1021);
    chk("b2b_gap", 32'(vrel[1] - vrel[0]), 32'd1020);
    cfg(1'b0, 0);
    repeat (3) step();

    // SYNC in the cycle after completion realigns cleanly
    cur_p = 0;
    for (int j = 0; j < 4; j++) fv[j] = 8'h96;
    cfg(1'b1, 0);
    step();
    nv = 0;
    start_frame(1'b0);
    run_to(254);
    for (int j = 0; j < 4; j++) fv[j] = 8'h69;
    start_frame(1'b0);
    run_to(256);
    chk("realign_nvalid", 32'(nv), 32'd2);
    chk("realign_val0", 32'(vval[0]), 32'h96);
    chk("realign_val1", 32'(vval[1]), 32'h69);
    chk("realign_when", 32'(vrel[1]), 32'd256);
    chk("realign_err", 32'(o_ERR), 32'h0);

    // EN=0 mid-frame aborts, value retained
    nv = 0;
    for (int j = 0; j < 4; j++) fv[j] = 8'h77;
    run_to(100);
    cfg(1'b0, 0);
    run_to(400);
    chk("abort_nvalid", 32'(nv), 32'd0);
    chk("abort_value", 32'(o_VALUE), 32'h69);

    // SYNC mid-frame with ERR_CLR in the same cycle: error wins
    cfg(1'b1, 0);
    step();
    for (int j = 0; j < 4; j++) fv[j] = 8'h5A;
    nv = 0;
    start_frame(1'b0);
    run_to(99);
    chk("pre_err", 32'(o_ERR), 32'h0);
    for (int j = 0; j < 4; j++) fv[j] = 8'h3C;
    start_frame(1'b1);
    chk("err_set", 32'(o_ERR), 32'h1);
    run_to(256);
    chk("err_nvalid", 32'(nv), 32'd1);
    chk("err_value", 32'(vval[0]), 32'h3C);
    chk("err_when", 32'(vrel[0]), 32'd256);
    chk("err_sticky", 32'(o_ERR), 32'h1);
    i_DIN_RE = 1'b1;
    step();
    i_DIN_RE = 1'b0;
    chk("din_read", o_DIN, 32'h0000013C);
    i_ERR_CLR = 1'b1;
    step();
    i_ERR_CLR = 1'b0;
    step();
    chk("err_clr", 32'(o_ERR), 32'h0);
    chk("din_hold", o_DIN, 32'h0000013C);
    i_DIN_RE = 1'b1;
    step();
    i_DIN_RE = 1'b0;
    chk("din_read2", o_DIN, 32'h0000003C);

    // reset mid-frame at tick 50
    for (int j = 0; j < 4; j++) fv[j] = 8'hE7;
    nv = 0;
    start_frame(1'b0);
    run_to(51);
    i_arst_n = 1'b0;
    #1;
    chk("arst_value", 32'(o_VALUE), 32'h0);
    chk("arst_valid", 32'(o_VALID), 32'h0);
    chk("arst_err", 32'(o_ERR), 32'h0);
    chk("arst_din", o_DIN, 32'h0);
    step();
    step();
    i_arst_n = 1'b1;
    run_to(200);
    start_frame(1'b0);
    run_to(600);
    chk("post_rst_nvalid", 32'(nv), 32'd0);
    chk("post_rst_value", 32'(o_VALUE), 32'h0);

    cfg(1'b1, 0);
    step();
    start_frame(1'b0);
    run_to(256);
    chk("recover_nvalid", 32'(nv), 32'd1);
    chk("recover_value", 32'(vval[0]), 32'hE7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
